// File: rtl/fq_wdrr.sv
// Weighted deficit round-robin merge of N show-ahead FIFOs onto one registered output.
// Each grant serves up to weight[i] words (0 counts as 1), then passes on via a one-cycle IDLE slot.
module fq_wdrr #(
    parameter int unsigned NUM_IN_LOG2 = 3,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned WEIGHT_W    = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [(1 << NUM_IN_LOG2)-1:0]                     fifo_empty,
    input  logic [(1 << NUM_IN_LOG2)-1:0][DATA_W-1:0]         fifo_data,
    output logic [(1 << NUM_IN_LOG2)-1:0]                     fifo_rdreq,
    input  logic [(1 << NUM_IN_LOG2)-1:0][WEIGHT_W-1:0]       weight,
    input  logic                                              output_ready,
    output logic [DATA_W-1:0]                                 output_data,
    output logic                                              output_data_valid,
    output logic [NUM_IN_LOG2-1:0]                            cur_chan
);

    localparam int unsigned N  = 1 << NUM_IN_LOG2;
    localparam int unsigned PW = NUM_IN_LOG2;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       chan_q, chan_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;

    logic                load;
    logic                pop;
    logic                any_ne;
    logic                found;
    logic [PW-1:0]       grant;
    logic [PW-1:0]       idx;
    logic [WEIGHT_W-1:0] grant_w;

    assign load   = !valid_q || output_ready;
    assign any_ne = ~&fifo_empty;
    assign pop    = (state_q == SERVE) && !fifo_empty[chan_q] && load;

    // First non-empty channel at or above ptr, wrapping modulo N.
    always_comb begin
        grant = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr_q + PW'(k);
            if (!found && !fifo_empty[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign grant_w = weight[grant];

    always_comb begin
        fifo_rdreq = '0;
        if (pop) begin
            fifo_rdreq[chan_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        chan_d   = chan_q;
        credit_d = credit_q;
        data_d   = data_q;
        valid_d  = valid_q;

        if (pop) begin
            data_d  = fifo_data[chan_q];
            valid_d = 1'b1;
        end else if (load) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (any_ne) begin
                    state_d  = SERVE;
                    chan_d   = grant;
                    credit_d = (grant_w == '0) ? WEIGHT_W'(1) : grant_w;
                end
            end
            SERVE: begin
                if (pop) begin
                    credit_d = credit_q - WEIGHT_W'(1);
                end
                // Turn ends on last credit consumed or when the granted FIFO runs dry.
                if ((pop && (credit_q == WEIGHT_W'(1))) || fifo_empty[chan_q]) begin
                    state_d = IDLE;
                    ptr_d   = chan_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            chan_q   <= '0;
            credit_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            chan_q   <= chan_d;
            credit_q <= credit_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign output_data       = data_q;
    assign output_data_valid = valid_q;
    assign cur_chan          = chan_q;

endmodule

// File: tb/tb_fq_wdrr.sv
// Bench for fq_wdrr: queue-backed upstream FIFOs, a turn-level reference model checked every
// cycle, a per-channel ordering scoreboard, directed scenarios and a randomized soak.
module tb_fq_wdrr;

    localparam int unsigned LOG2 = 2;
    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 64;
    localparam int unsigned WW   = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [N-1:0]               fifo_empty;
    logic [N-1:0][DW-1:0]       fifo_data;
    logic [N-1:0]               fifo_rdreq;
    logic [N-1:0][WW-1:0]       weight;
    logic                       output_ready;
    logic [DW-1:0]              output_data;
    logic                       output_data_valid;
    logic [LOG2-1:0]            cur_chan;

    fq_wdrr #(.NUM_IN_LOG2(LOG2), .DATA_W(DW), .WEIGHT_W(WW)) dut (
        .clk               (clk),
        .rst               (rst),
        .fifo_empty        (fifo_empty),
        .fifo_data         (fifo_data),
        .fifo_rdreq        (fifo_rdreq),
        .weight            (weight),
        .output_ready      (output_ready),
        .output_data       (output_data),
        .output_data_valid (output_data_valid),
        .cur_chan          (cur_chan)
    );

    always #5 clk = ~clk;

    // upstream FIFO contents and per-channel sequence tracking
    logic [DW-1:0] q [N][$];
    int            push_seq [N];
    int            acc_seq  [N];
    int            acc_log  [$];
    bit            vlog     [$];

    // reference model: serving flag, granted channel, words left in turn, search pointer
    bit            m_serve;
    int            m_chan;
    int            m_credit;
    int            m_ptr;
    bit            m_valid;
    logic [DW-1:0] m_data;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = (q[i].size() == 0);
            fifo_data[i]  = (q[i].size() == 0) ? 64'hDEAD_BEEF_DEAD_BEEF : q[i][0];
        end
    endtask

    task automatic push(input int c, input int n);
        repeat (n) begin
            q[c].push_back({32'(c), 32'(push_seq[c])});
            push_seq[c]++;
        end
    endtask

    task automatic clear_env();
        for (int c = 0; c < N; c++) begin
            q[c].delete();
            push_seq[c] = 0;
        end
        acc_log.delete();
        vlog.delete();
    endtask

    task automatic model_reset();
        logic [DW-1:0] w;
        m_serve  = 1'b0;
        m_chan   = 0;
        m_credit = 0;
        m_ptr    = 0;
        m_valid  = 1'b0;
        m_data   = '0;
        for (int c = 0; c < N; c++) begin
            if (q[c].size() > 0) begin
                w = q[c][0];
                acc_seq[c] = int'(w[31:0]);
            end else begin
                acc_seq[c] = push_seq[c];
            end
        end
    endtask

    // advance the model across one clock edge using the pre-edge inputs
    task automatic model_update();
        bit load;
        bit endt;
        load = !m_valid || output_ready;
        endt = 1'b0;
        if (!m_serve) begin
            if (load) m_valid = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (q[c].size() > 0) begin
                    m_chan   = c;
                    m_credit = (int'(weight[c]) == 0) ? 1 : int'(weight[c]);
                    m_serve  = 1'b1;
                    break;
                end
            end
        end else begin
            if (q[m_chan].size() > 0 && load) begin
                m_data  = q[m_chan][0];
                m_valid = 1'b1;
                m_credit--;
                if (m_credit == 0) endt = 1'b1;
            end else if (load) begin
                m_valid = 1'b0;
            end
            if (q[m_chan].size() == 0) endt = 1'b1;
            if (endt) begin
                m_serve = 1'b0;
                m_ptr   = (m_chan + 1) % N;
            end
        end
    endtask

    // one clock: starts and ends just after a rising edge
    task automatic step();
        logic [N-1:0]  rd;
        logic [N-1:0]  m_rd;
        logic [DW-1:0] accw;
        bit            acc;
        int            c;
        drive_fifo();
        #1;
        m_rd = '0;
        if (m_serve && q[m_chan].size() > 0 && (!m_valid || output_ready)) m_rd[m_chan] = 1'b1;
        check("rdreq", 64'(fifo_rdreq), 64'(m_rd));
        rd   = fifo_rdreq;
        acc  = output_data_valid && output_ready;
        accw = output_data;
        model_update();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (rd[i] && q[i].size() > 0) void'(q[i].pop_front());
        end
        if (acc) begin
            c = int'(accw[33:32]);
            check("order", 64'(accw[31:0]), 64'(acc_seq[c]));
            acc_seq[c] = int'(accw[31:0]) + 1;
            acc_log.push_back(c);
        end
        #1;
        check("valid", 64'(output_data_valid), 64'(m_valid));
        check("data", output_data, m_data);
        check("cur_chan", 64'(cur_chan), 64'(m_chan));
        vlog.push_back(output_data_valid);
    endtask

    task automatic hold_reset(input int cycles);
        rst = 1'b0;
        model_reset();
        drive_fifo();
        #1;
        repeat (cycles) begin
            check("rst_valid", 64'(output_data_valid), 64'(0));
            check("rst_data", output_data, 64'(0));
            check("rst_chan", 64'(cur_chan), 64'(0));
            check("rst_rdreq", 64'(fifo_rdreq), 64'(0));
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
        weight[0] = WW'(w0);
        weight[1] = WW'(w1);
        weight[2] = WW'(w2);
        weight[3] = WW'(w3);
    endtask

    int  exp29 [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    bit  pat29 [15] = '{0, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit  pat30 [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    int  exp32 [5]  = '{0, 0, 1, 1, 1};

    initial begin
        int  guard;
        int  left;
        rst          = 1'b0;
        output_ready = 1'b1;
        weight       = '0;
        fifo_empty   = '1;
        fifo_data    = '0;
        @(posedge clk);
        #1;

        // reset with every channel loaded, then weighted round at full rate
        clear_env();
        set_weights(1, 2, 3, 4);
        for (int c = 0; c < N; c++) push(c, 20);
        hold_reset(4);
        output_ready = 1'b1;
        repeat (60) step();
        for (int i = 0; i < 10; i++)
            check("seq29", (i < acc_log.size()) ? 64'(acc_log[i]) : 64'(-1), 64'(exp29[i]));
        for (int i = 0; i < 15; i++)
            check("bubble29", (i < vlog.size()) ? 64'(vlog[i]) : 64'(2), 64'(pat29[i]));

        // single channel with weight 0: one-word turns
        clear_env();
        set_weights(3, 3, 0, 3);
        push(2, 5);
        hold_reset(2);
        repeat (20) step();
        for (int i = 0; i < 12; i++)
            check("bubble30", (i < vlog.size()) ? 64'(vlog[i]) : 64'(2), 64'(pat30[i]));
        check("count30", 64'(acc_log.size()), 64'(5));

        // backpressure mid-turn on ch1
        clear_env();
        set_weights(4, 4, 4, 4);
        for (int c = 0; c < N; c++) push(c, 8);
        hold_reset(2);
        guard = 0;
        while (!(output_data_valid && cur_chan == 2'd1) && guard < 50) begin
            step();
            guard++;
        end
        check("timeout31", 64'(guard < 50), 64'(1));
        output_ready = 1'b0;
        repeat (3) begin
            step();
            check("stall31_data", output_data, 64'h0000_0001_0000_0000);
            check("stall31_valid", 64'(output_data_valid), 64'(1));
        end
        output_ready = 1'b1;
        repeat (40) step();
        check("drain31", 64'(q[1].size()), 64'(0));

        // large weight, few words: turn ends on empty
        clear_env();
        set_weights(8, 1, 1, 1);
        push(0, 2);
        push(1, 3);
        hold_reset(2);
        repeat (20) step();
        for (int i = 0; i < 5; i++)
            check("seq32", (i < acc_log.size()) ? 64'(acc_log[i]) : 64'(-1), 64'(exp32[i]));
        check("chan32", 64'(cur_chan), 64'(1));

        // reset pulse during ch3 turn
        clear_env();
        set_weights(2, 2, 2, 2);
        for (int c = 0; c < N; c++) push(c, 6);
        hold_reset(2);
        guard = 0;
        while (!(output_data_valid && cur_chan == 2'd3) && guard < 60) begin
            step();
            guard++;
        end
        check("timeout33", 64'(guard < 60), 64'(1));
        rst = 1'b0;
        #1;
        check("async33_valid", 64'(output_data_valid), 64'(0));
        hold_reset(2);
        step();
        check("regrant33", 64'(cur_chan), 64'(0));
        repeat (60) step();

        // randomized soak with a mid-run reset
        clear_env();
        set_weights($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        hold_reset(2);
        for (int t = 0; t < 2500; t++) begin
            output_ready = ($urandom_range(0, 9) < 7);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 99) < 15 && q[c].size() < 30) push(c, $urandom_range(1, 3));
            end
            if (t == 1200) hold_reset(2);
            step();
        end
        output_ready = 1'b1;
        guard = 0;
        left  = 1;
        while (left != 0 && guard < 400) begin
            step();
            guard++;
            left = 0;
            for (int c = 0; c < N; c++) left += q[c].size();
            if (output_data_valid) left++;
        end
        check("drained", 64'(left), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
